// File: rtl/reg_skid_div_pkg.sv
// Shared definitions for the skid-buffered divider result register:
// controller state encodings and the default datapath width.
package reg_skid_div_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   // Occupancy implied by a state; the unused encoding reads as empty.
   function automatic logic [1:0] state_count(input logic [1:0] st);
      logic [1:0] n;
      case (st)
         ST_FULL: n = 2'd1;
         ST_SKID: n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/reg_skid_div_reg_n_en.sv
// WIDTH-bit enable register with synchronous clear to RESET_VAL,
// built one flop per bit so each bit picks up its own reset constant.
module reg_n_en
   import reg_skid_div_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_ff @(posedge clk) begin
            if (clr) begin
               r_q[gi] <= RESET_VAL[gi];
            end else if (en) begin
               r_q[gi] <= d[gi];
            end
         end
      end
   endgenerate

   assign q = r_q;

endmodule

// File: rtl/reg_skid_div.sv
// Divider result pipeline register with valid/ready handshake and a one-entry
// skid buffer; every output is a flop or a decode of the state register.
module reg_skid_div
   import reg_skid_div_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic [1:0]       count
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic             w_main_en;
   logic             w_skid_en;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   always_comb begin
      w_state_next = r_state;
      w_main_en    = 1'b0;
      w_skid_en    = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (in_valid) begin
               w_main_en    = 1'b1;
               w_state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (in_valid && out_ready) begin
               w_main_en = 1'b1;
            end else if (in_valid) begin
               w_skid_en    = 1'b1;
               w_state_next = ST_SKID;
            end else if (out_ready) begin
               w_state_next = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (out_ready) begin
               w_main_en    = 1'b1;
               w_state_next = ST_FULL;
            end
         end
         default: w_state_next = ST_EMPTY;
      endcase
      // Flush drops occupancy but leaves the stored words untouched.
      if (flush) begin
         w_state_next = ST_EMPTY;
         w_main_en    = 1'b0;
         w_skid_en    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   assign w_main_d = (r_state == ST_SKID) ? w_skid_q : data_in;

   reg_n_en #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .clk (clk),
      .clr (clr),
      .en  (w_main_en),
      .d   (w_main_d),
      .q   (w_main_q)
   );

   reg_n_en #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .clk (clk),
      .clr (clr),
      .en  (w_skid_en),
      .d   (data_in),
      .q   (w_skid_q)
   );

   assign in_ready  = (r_state == ST_EMPTY) || (r_state == ST_FULL);
   assign out_valid = (r_state == ST_FULL)  || (r_state == ST_SKID);
   assign count     = state_count(r_state);
   assign data_out  = w_main_q;

endmodule

// File: tb/tb_reg_skid_div.sv
// Bench for reg_skid_div: four instances (32-bit, 32-bit with DEADBEEF reset,
// 1-bit, 64-bit) share controls and are checked against a 2-deep FIFO model.
module tb_reg_skid_div;

   logic        clk = 1'b0;
   logic        clr;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] din;

   logic        rdy32, ov32, rdyb, ovb, rdy1, ov1, rdy64, ov64;
   logic [1:0]  cnt32, cntb, cnt1, cnt64;
   logic [31:0] do32, dob;
   logic [0:0]  do1;
   logic [63:0] do64;

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] q[$];
   logic [63:0] m_last = '0;
   bit          m_rst = 1'b1;

   always #5 clk = ~clk;

   reg_skid_div #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .data_in(din[31:0]), .out_valid(ov32), .out_ready(out_ready),
      .data_out(do32), .count(cnt32));

   reg_skid_div #(.WIDTH(32), .RESET_VAL(32'hDEAD_BEEF)) dutb (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdyb),
      .data_in(din[31:0]), .out_valid(ovb), .out_ready(out_ready),
      .data_out(dob), .count(cntb));

   reg_skid_div #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .data_in(din[0:0]), .out_valid(ov1), .out_ready(out_ready),
      .data_out(do1), .count(cnt1));

   reg_skid_div #(.WIDTH(64), .RESET_VAL(64'h0)) dut64 (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .data_in(din), .out_valid(ov64), .out_ready(out_ready),
      .data_out(do64), .count(cnt64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      logic        e_rdy;
      logic        e_ov;
      logic [1:0]  e_cnt;
      logic [31:0] e_beef;
      e_rdy  = (q.size() < 2);
      e_ov   = (q.size() > 0);
      e_cnt  = 2'(q.size());
      e_beef = m_rst ? 32'hDEAD_BEEF : m_last[31:0];
      chk({ph, ".in_ready"},  {60'd0, rdy32, rdyb, rdy1, rdy64}, {60'd0, {4{e_rdy}}});
      chk({ph, ".out_valid"}, {60'd0, ov32, ovb, ov1, ov64},     {60'd0, {4{e_ov}}});
      chk({ph, ".count"},     {56'd0, cnt32, cntb, cnt1, cnt64}, {56'd0, {4{e_cnt}}});
      chk({ph, ".data32"},    {32'd0, do32}, {32'd0, m_last[31:0]});
      chk({ph, ".data_beef"}, {32'd0, dob},  {32'd0, e_beef});
      chk({ph, ".data1"},     {63'd0, do1},  {63'd0, m_last[0]});
      chk({ph, ".data64"},    do64, m_last);
   endtask

   // Reference: a FIFO of capacity two; the visible word is the head, or the
   // last head seen once the FIFO drains or is flushed.
   task automatic step(input logic c, input logic f, input logic iv,
                       input logic [63:0] d, input logic ordy, input string ph);
      int  sz;
      bit  pop;
      bit  push;
      clr = c; flush = f; in_valid = iv; din = d; out_ready = ordy;
      sz = q.size();
      if (c) begin
         q.delete();
         m_last = '0;
         m_rst  = 1'b1;
      end else if (f) begin
         q.delete();
      end else begin
         pop  = (sz > 0) && ordy;
         push = iv && (sz < 2);
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(d);
         if (q.size() > 0) begin
            m_last = q[0];
            m_rst  = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_all(ph);
      $display("step %-6s clr=%0b flush=%0b iv=%0b din=%h ordy=%0b -> cnt=%0d out=%h",
               ph, c, f, iv, d, ordy, cnt64, do64);
   endtask

   initial begin
      logic [63:0] pat;
      clr = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; din = '1;
      @(negedge clk);

      // Reset with garbage on every input
      step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "rst");
      step(1'b1, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, "rst");

      // Streaming 1..8 with out_ready high
      for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 64'(i), 1'b1, "strm");
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, "strm");

      // Back-pressure: A, B fill; C offered for 3 cycles while stalled
      step(1'b0, 1'b0, 1'b1, 64'hA, 1'b0, "bp");
      step(1'b0, 1'b0, 1'b1, 64'hB, 1'b0, "bp");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 64'hC, 1'b0, "bp");
      step(1'b0, 1'b0, 1'b1, 64'hC, 1'b1, "bp");
      step(1'b0, 1'b0, 1'b1, 64'hC, 1'b1, "bp");
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, "bp");

      // Flush with a simultaneous push, then resume
      step(1'b0, 1'b0, 1'b1, 64'h11, 1'b0, "fl");
      step(1'b0, 1'b0, 1'b1, 64'h22, 1'b0, "fl");
      step(1'b0, 1'b1, 1'b1, 64'h33, 1'b1, "fl");
      step(1'b0, 1'b0, 1'b1, 64'h44, 1'b0, "fl");

      // Clear while full with both handshakes active
      step(1'b0, 1'b0, 1'b1, 64'h55, 1'b0, "clr");
      step(1'b1, 1'b0, 1'b1, 64'h66, 1'b1, "clr");
      step(1'b0, 1'b0, 1'b0, 64'h77, 1'b1, "clr");

      // Width sweep with edge-bit patterns
      pat = 64'h8000_0000_0000_0001;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b1, (i % 2 == 1) ? ~pat : pat, 1'b1, "wid");
         pat = {pat[62:0], pat[63]};
      end
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, "wid");

      // Randomised traffic with occasional flush and clear
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 60) == 0, ($urandom % 30) == 0, 1'($urandom),
              {$urandom, $urandom}, ($urandom % 3) != 0, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
